// File: rtl/iic_slave.sv
// I2C target: filtered SCL/SDA sampling, START/STOP detection, 7-bit address match, byte receive/transmit.
// Optional clock stretching on read-data underrun is enabled by defining IIC_SLAVE_STRETCH_EN.
module iic_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned HOLD_CYC   = 8,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       tx_req,
    output logic       tx_nack,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);

    logic [1:0]          scl_sync, sda_sync;
    logic [FILT_LEN-2:0] scl_hist, sda_hist;
    logic [FILT_LEN-1:0] scl_win, sda_win;
    logic                scl_f, sda_f, scl_p, sda_p;
    logic                scl_rise, scl_fall, start_det, stop_det, tx_due;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        byte_done, rw, first_byte;
    logic        sda_oe, hold_pend, hold_val;
    logic [15:0] hold_cnt;

    // Window = previous FILT_LEN-1 samples plus the current one, so the filtered level
    // moves 2+FILT_LEN cycles after the pin.
    assign scl_win = {scl_hist, scl_sync[1]};
    assign sda_win = {sda_hist, sda_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_hist <= scl_win[FILT_LEN-2:0];
            sda_hist <= sda_win[FILT_LEN-2:0];
            if (&scl_win)       scl_f <= 1'b1;
            else if (~|scl_win) scl_f <= 1'b0;
            if (&sda_win)       sda_f <= 1'b1;
            else if (~|sda_win) sda_f <= 1'b0;
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = sda_p & ~sda_f & scl_f;
    assign stop_det  = ~sda_p & sda_f & scl_f;
    // A falling edge in RD_ACK only happens after an ACK; a NACK leaves for IDLE on the rising edge.
    assign tx_due    = scl_fall & (((state == ADDR_ACK) & rw) | (state == RD_ACK));

    assign sda = sda_oe ? 1'b0 : 1'bz;

`ifdef IIC_SLAVE_STRETCH_EN
    logic        scl_oe, stall, rel_pend, wr_hold;
    logic [15:0] rel_cnt;
    assign scl = scl_oe ? 1'b0 : 1'bz;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_done  <= 1'b0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            sda_oe     <= 1'b0;
            hold_pend  <= 1'b0;
            hold_val   <= 1'b0;
            hold_cnt   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
            tx_nack    <= 1'b0;
            busy       <= 1'b0;
`ifdef IIC_SLAVE_STRETCH_EN
            scl_oe     <= 1'b0;
            stall      <= 1'b0;
            rel_pend   <= 1'b0;
            wr_hold    <= 1'b0;
            rel_cnt    <= '0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req   <= 1'b0;
            tx_nack  <= 1'b0;
            if (hold_pend) begin
                if (hold_cnt == '0) begin
                    sda_oe    <= hold_val;
                    hold_pend <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt - 16'd1;
                end
            end
`ifdef IIC_SLAVE_STRETCH_EN
            if (rel_pend) begin
                if (rel_cnt == '0) begin
                    scl_oe   <= 1'b0;
                    rel_pend <= 1'b0;
                end else begin
                    rel_cnt <= rel_cnt - 16'd1;
                end
            end
            if (wr_hold) begin
                scl_oe  <= 1'b0;
                wr_hold <= 1'b0;
            end
            if (start_det || stop_det) begin
                scl_oe   <= 1'b0;
                stall    <= 1'b0;
                rel_pend <= 1'b0;
                wr_hold  <= 1'b0;
            end
`endif
            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= '0;
                byte_done  <= 1'b0;
                first_byte <= 1'b1;
                sda_oe     <= 1'b0;
                hold_pend  <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                busy      <= 1'b0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
                hold_pend <= 1'b0;
`ifdef IIC_SLAVE_STRETCH_EN
            // SCL is already held low here, so the MSB goes out at once and SCL follows HOLD_CYC later.
            end else if (stall) begin
                if (tx_ready) begin
                    state    <= RD_BYTE;
                    shreg    <= tx_data;
                    bit_cnt  <= '0;
                    stall    <= 1'b0;
                    sda_oe   <= ~tx_data[7];
                    rel_pend <= 1'b1;
                    rel_cnt  <= HOLD_LOAD;
                end
            end else if (tx_due && !tx_ready) begin
                stall  <= 1'b1;
                scl_oe <= 1'b1;
`endif
            end else if (tx_due) begin
                state     <= RD_BYTE;
                shreg     <= tx_data;
                bit_cnt   <= '0;
                hold_pend <= 1'b1;
                hold_cnt  <= HOLD_LOAD;
                hold_val  <= ~tx_data[7];
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg     <= {shreg[6:0], sda_f};
                            bit_cnt   <= bit_cnt + 3'd1;
                            byte_done <= (bit_cnt == 3'd7);
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                state     <= ADDR_ACK;
                                rw        <= shreg[0];
                                busy      <= 1'b1;
                                hold_pend <= 1'b1;
                                hold_cnt  <= HOLD_LOAD;
                                hold_val  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && rw) begin
                            tx_req <= 1'b1;
                        end else if (scl_fall) begin
                            state     <= WR_BYTE;
                            bit_cnt   <= '0;
                            hold_pend <= 1'b1;
                            hold_cnt  <= HOLD_LOAD;
                            hold_val  <= 1'b0;
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data    <= {shreg[6:0], sda_f};
                                rx_valid   <= 1'b1;
                                rx_first   <= first_byte;
                                first_byte <= 1'b0;
                                byte_done  <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            state     <= WR_ACK;
                            hold_pend <= 1'b1;
                            hold_cnt  <= HOLD_LOAD;
                            hold_val  <= 1'b1;
`ifdef IIC_SLAVE_STRETCH_EN
                            scl_oe  <= 1'b1;
                            wr_hold <= 1'b1;
`endif
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            state     <= WR_BYTE;
                            hold_pend <= 1'b1;
                            hold_cnt  <= HOLD_LOAD;
                            hold_val  <= 1'b0;
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            hold_pend <= 1'b1;
                            hold_cnt  <= HOLD_LOAD;
                            if (bit_cnt == 3'd7) begin
                                state    <= RD_ACK;
                                bit_cnt  <= '0;
                                hold_val <= 1'b0;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 3'd1;
                                hold_val <= ~shreg[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                tx_nack <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                tx_req <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iic_slave.sv
// Self-checking bench for iic_slave: bus-level master tasks, directed transaction table,
// random transactions checked against a transaction-level model, and abort/reset/stretch cases.
module tb_iic_slave;
    localparam int HP = 48;
    localparam int Q  = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wire scl, sda;
    pullup (scl);
    pullup (sda);
    logic m_scl_oe = 1'b0, m_sda_oe = 1'b0;
    assign scl = m_scl_oe ? 1'b0 : 1'bz;
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_first, tx_ready, tx_req, tx_nack, busy;

    iic_slave #(.SLAVE_ADDR(7'h50), .HOLD_CYC(8), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_req(tx_req),
        .tx_nack(tx_nack), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: every observed event is recorded, never interpreted here.
    logic [8:0] rx_q[$];
    int txreq_cnt = 0, nack_cnt = 0, slave_low_cnt = 0;
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back({rx_first, rx_data});
        if (tx_req) txreq_cnt++;
        if (tx_nack) nack_cnt++;
        if (sda === 1'b0 && !m_sda_oe) slave_low_cnt++;
    end

    int last_wait;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic scl_up();
        bit up;
        up = 1'b0;
        last_wait = 0;
        m_scl_oe = 1'b0;
        for (int i = 0; i < 5000 && !up; i++) begin
            @(posedge clk);
            last_wait++;
            if (scl === 1'b1) up = 1'b1;
        end
        if (!up) begin
            n_checks++;
            n_fail++;
            $display("FAIL scl_release_timeout: got 0, expected 1");
        end
    endtask

    // Entry/exit point: SCL low, Q cycles after its falling edge.
    task automatic do_bit(input logic b, output logic s);
        m_sda_oe = ~b;
        cyc(Q);
        scl_up();
        cyc(Q);
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        cyc(Q);
        m_scl_oe = 1'b1;
        cyc(Q);
    endtask

    task automatic bus_start();
        m_sda_oe = 1'b1;
        cyc(HP);
        m_scl_oe = 1'b1;
        cyc(Q);
    endtask

    task automatic bus_rstart();
        m_sda_oe = 1'b0;
        cyc(Q);
        scl_up();
        cyc(Q);
        m_sda_oe = 1'b1;
        cyc(Q);
        m_scl_oe = 1'b1;
        cyc(Q);
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1;
        cyc(Q);
        scl_up();
        cyc(Q);
        m_sda_oe = 1'b0;
        cyc(HP);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) do_bit(b[i], s);
        do_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            do_bit(1'b1, s);
            v[i] = s;
        end
        tx_data = next_tx;
        do_bit(ack_bit, s);
    endtask

    typedef struct {
        logic [7:0]  addr_byte;
        int unsigned n;
        logic [23:0] d;
        logic        exp_aack;
        int unsigned exp_nrx;
        int unsigned exp_nreq;
        int unsigned exp_nnack;
    } txn_t;

    // Transaction-level model: what a 7'h50 target must do for a whole transfer.
    function automatic txn_t model(input logic [7:0] ab, input int unsigned n, input logic [23:0] d);
        txn_t t;
        bit   hit;
        hit         = (ab[7:1] == 7'h50);
        t.addr_byte = ab;
        t.n         = n;
        t.d         = d;
        t.exp_aack  = !hit;
        t.exp_nrx   = (hit && !ab[0]) ? n : 0;
        t.exp_nreq  = (hit && ab[0]) ? n : 0;
        t.exp_nnack = (hit && ab[0]) ? 1 : 0;
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        logic       a;
        logic [7:0] v, nxt;
        logic [8:0] got;
        int req0, nack0, low0;
        rx_q.delete();
        req0  = txreq_cnt;
        nack0 = nack_cnt;
        low0  = slave_low_cnt;
        tx_data = t.d[7:0];
        bus_start();
        wr_byte(t.addr_byte, a);
        check("addr_ack", a, t.exp_aack);
        check("busy_mid", busy, !t.exp_aack);
        for (int i = 0; i < int'(t.n); i++) begin
            if (t.addr_byte[0]) begin
                nxt = (i + 1 < int'(t.n)) ? t.d[8*(i+1) +: 8] : 8'h00;
                rd_byte(i + 1 == int'(t.n), nxt, v);
                check("rd_byte", v, t.exp_aack ? 8'hFF : t.d[8*i +: 8]);
            end else begin
                wr_byte(t.d[8*i +: 8], a);
                check("wr_ack", a, t.exp_aack);
            end
        end
        bus_stop();
        check("busy_after_stop", busy, 0);
        check("rx_count", rx_q.size(), t.exp_nrx);
        for (int i = 0; i < int'(t.exp_nrx) && rx_q.size() > 0; i++) begin
            got = rx_q.pop_front();
            check("rx_first_data", got, {i == 0, t.d[8*i +: 8]});
        end
        check("tx_req_count", txreq_cnt - req0, t.exp_nreq);
        check("tx_nack_count", nack_cnt - nack0, t.exp_nnack);
        if (t.exp_aack) check("no_slave_drive", slave_low_cnt - low0, 0);
    endtask

    txn_t       vec[4];
    txn_t       rt;
    logic [6:0] a7;
    logic       a, s;
    logic [7:0] v;
    logic [8:0] got;
    int         req0, nack0, low_len;

    initial begin
        vec[0] = '{8'hA0, 2, 24'h00C33C, 1'b0, 2, 0, 0};
        vec[1] = '{8'hA2, 1, 24'h000011, 1'b1, 0, 0, 0};
        vec[2] = '{8'hA1, 2, 24'h00FF5A, 1'b0, 0, 2, 1};
        vec[3] = '{8'hA0, 1, 24'h000055, 1'b0, 1, 0, 0};

        rst = 1'b1;
        tx_data = 8'h00;
        tx_ready = 1'b1;
        cyc(5);
        @(negedge clk);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {rx_valid, rx_first, tx_req, tx_nack}, 0);
        check("rst_sda", sda, 1);
        check("rst_scl", scl, 1);
        rst = 1'b0;
        cyc(HP);

        foreach (vec[i]) run_txn(vec[i]);

        for (int k = 0; k < 10; k++) begin
            a7 = 7'h50;
            if ($urandom_range(0, 9) < 4) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h50) a7 = 7'h51;
            end
            rt = model({a7, 1'($urandom_range(0, 1))}, $urandom_range(1, 3), 24'($urandom));
            run_txn(rt);
        end

        // Write 0x07, repeated START, read one byte with NACK.
        rx_q.delete();
        req0  = txreq_cnt;
        nack0 = nack_cnt;
        tx_data = 8'h96;
        bus_start();
        wr_byte(8'hA0, a);
        wr_byte(8'h07, a);
        check("sr_wr_ack", a, 0);
        bus_rstart();
        check("sr_busy_after_sr", busy, 1);
        check("sr_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            check("sr_rx", got, 9'h107);
        end
        wr_byte(8'hA1, a);
        check("sr_addr_ack", a, 0);
        rd_byte(1'b1, 8'h00, v);
        check("sr_rd_byte", v, 8'h96);
        check("sr_busy_before_stop", busy, 1);
        bus_stop();
        check("sr_busy_after_stop", busy, 0);
        check("sr_tx_req", txreq_cnt - req0, 1);
        check("sr_tx_nack", nack_cnt - nack0, 1);

        // STOP after four bits of a data byte discards it.
        rx_q.delete();
        bus_start();
        wr_byte(8'hA0, a);
        do_bit(1'b1, s);
        do_bit(1'b0, s);
        do_bit(1'b1, s);
        do_bit(1'b1, s);
        bus_stop();
        check("abort_rx_count", rx_q.size(), 0);
        check("abort_busy", busy, 0);
        check("abort_sda", sda, 1);
        run_txn(vec[3]);

        // Reset while the target is driving a read bit low.
        tx_data = 8'h00;
        bus_start();
        wr_byte(8'hA1, a);
        do_bit(1'b1, s);
        do_bit(1'b1, s);
        do_bit(1'b1, s);
        check("rdrst_sda_driven", sda, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rdrst_sda_released", sda, 1);
        check("rdrst_rx_data", rx_data, 0);
        check("rdrst_busy", busy, 0);
        check("rdrst_pulses", {rx_valid, rx_first, tx_req, tx_nack}, 0);
        @(negedge clk);
        rst = 1'b0;
        scl_up();
        cyc(HP);
        run_txn(vec[0]);

`ifdef IIC_SLAVE_STRETCH_EN
        tx_ready = 1'b0;
        tx_data  = 8'h5A;
        fork
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20000 && !seen; i++) begin
                    @(negedge clk);
                    if (tx_req) seen = 1'b1;
                end
                repeat (500) @(posedge clk);
                tx_ready = 1'b1;
            end
        join_none
        bus_start();
        wr_byte(8'hA1, a);
        check("st_addr_ack", a, 0);
        do_bit(1'b1, s);
        low_len = last_wait + HP;
        v[7] = s;
        for (int i = 6; i >= 0; i--) begin
            do_bit(1'b1, s);
            v[i] = s;
        end
        do_bit(1'b1, s);
        bus_stop();
        check("st_rd_byte", v, 8'h5A);
        check("st_low_len_ok", (low_len >= 440 && low_len <= 540), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
